ysyx_24100005_register_file: RTL and testbench
==============================================

YSYX_24100005_REGISTER_FILE -- requirements
Module: ysyx_24100005_register_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving the register address width and a depth of 2^ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the register data width.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset; sampled only at a rising clk edge.
REQ-006 wen  input  1  write enable, active-high.
REQ-007 waddr  input  ADDR_WIDTH  write address.
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 rs1addr  input  ADDR_WIDTH  read port 1 address.
REQ-010 rs2addr  input  ADDR_WIDTH  read port 2 address.
REQ-011 rs1data  output  DATA_WIDTH  read port 1 data.
REQ-012 rs2data  output  DATA_WIDTH  read port 2 data.

Function
REQ-013 SHALL hold 2^ADDR_WIDTH registers of DATA_WIDTH bits each; entry 0 is hardwired zero.
REQ-014 Read ports SHALL be combinational with zero latency: rs1data = reg[rs1addr] and rs2data = reg[rs2addr] in the same cycle, with no clock involved.
REQ-015 Reads of address 0 SHALL return 0 on either port, regardless of any write history.
REQ-016 On a rising clk edge with rst=1, wen=1 and waddr!=0, reg[waddr] SHALL take wdata.
REQ-017 Writes with waddr=0 SHALL be discarded silently.
REQ-018 With wen=0, no entry SHALL change.
REQ-019 There SHALL be no write-to-read bypass: in the cycle of a write, a read of waddr returns the old value; the new value appears after the edge.
REQ-020 Both ports reading the same address SHALL return identical data.
REQ-021 Only the addressed entry SHALL change on a write; all other entries hold their values.
REQ-022 Addresses SHALL use the full ADDR_WIDTH range with no wrap-around or aliasing; every index 0 to 2^ADDR_WIDTH-1 is valid.
REQ-023 Outputs SHALL be free of X once reset has been applied.

Reset
REQ-024 On a rising clk edge with rst=0, every entry SHALL clear to 0.
REQ-025 Reset SHALL take priority over a write in the same cycle: a simultaneous wen=1 is ignored and the target entry becomes 0.
REQ-026 Deasserting or asserting rst between clock edges SHALL have no effect until the next rising edge (synchronous only).
REQ-027 While rst=0 is held, read ports SHALL still be combinational and return 0 for all addresses after the first reset edge.
REQ-028 Reset asserted in the middle of a sequence of writes SHALL clear all previously written entries at that edge.

Verification
REQ-029 Reset then read: rst=0 for one edge, then rst=1; read all 32 addresses on both ports -> every value is 0x00000000.
REQ-030 Write then read: write 0xDEADBEEF to x5 (wen=1, waddr=5); after the edge, rs1addr=5 and rs2addr=5 -> both ports read 0xDEADBEEF, and x4 and x6 read 0.
REQ-031 x0 protection: write 0xFFFFFFFF to waddr=0 -> rs1data for rs1addr=0 stays 0x00000000.
REQ-032 No bypass: during the cycle writing 0x12345678 to x10, read x10 -> returns its old value (0); after the edge -> returns 0x12345678.
REQ-033 Reset priority: rst=0 together with wen=1, waddr=7, wdata=0xA5A5A5A5 at the same edge -> x7 reads 0; an earlier-written x5 also reads 0.
REQ-034 Write gating and full range: wen=0 with waddr=31, wdata=0x1 -> x31 unchanged; then wen=1 -> x31 reads 0x00000001, and x1..x30 written with distinct values all read back correctly.

Source files
------------

// File: rtl/ysyx_24100005_register_file.sv
// ----------------------------------------------------------------------------
// ysyx_24100005_register_file
//   General-purpose register file: 2^ADDR_WIDTH entries of DATA_WIDTH bits,
//   one synchronous write port, two combinational read ports. Entry 0 always
//   reads as zero and ignores writes. No write-to-read bypass: a write becomes
//   visible only after the clock edge that commits it.
//
// Ports
//   clk      in   clock, all state changes on rising edge
//   rst      in   synchronous active-low reset, clears every entry
//   wen      in   write enable (active-high)
//   waddr    in   write address
//   wdata    in   write data
//   rs1addr  in   read port 1 address
//   rs2addr  in   read port 2 address
//   rs1data  out  read port 1 data (combinational)
//   rs2data  out  read port 2 data (combinational)
// ----------------------------------------------------------------------------
module ysyx_24100005_register_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] rs1addr,
  input  logic [ADDR_WIDTH-1:0] rs2addr,
  output logic [DATA_WIDTH-1:0] rs1data,
  output logic [DATA_WIDTH-1:0] rs2data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Reset wins over a coincident write; entry 0 is never written so it stays
  // at its reset value, and the read mux below forces it to zero regardless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rs1data = '0;
    rs2data = '0;
    if (rs1addr != '0) rs1data = regs[rs1addr];
    if (rs2addr != '0) rs2data = regs[rs2addr];
  end

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24100005_register_file
//   Directed self-checking bench for the register file. Inputs change 1ns
//   after the rising edge; combinational reads are sampled 1ns after the
//   address is applied, well away from the clock edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24100005_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  rs1addr;
  logic [4:0]  rs2addr;
  logic [31:0] rs1data;
  logic [31:0] rs2data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_val [32];

  ysyx_24100005_register_file #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .rs1addr (rs1addr),
    .rs2addr (rs2addr),
    .rs1data (rs1data),
    .rs2data (rs2data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read2(input logic [4:0] a1, input logic [4:0] a2);
    rs1addr = a1;
    rs2addr = a2;
    #1;
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; rs1addr = '0; rs2addr = '0;

    // Reset edge, still held low: reads must already be zero.
    tick();
    for (int i = 0; i < 32; i += 7) begin
      read2(5'(i), 5'(31 - i));
      check($sformatf("rst_hold_rs1_x%0d", i), rs1data, 32'h0);
      check($sformatf("rst_hold_rs2_x%0d", 31 - i), rs2data, 32'h0);
    end
    rst = 1'b1;

    // Reset then read all addresses on both ports.
    for (int i = 0; i < 32; i++) begin
      read2(5'(i), 5'(i));
      check($sformatf("post_rst_rs1_x%0d", i), rs1data, 32'h0);
      check($sformatf("post_rst_rs2_x%0d", i), rs2data, 32'h0);
    end

    // Write x5, no bypass during the write cycle.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    read2(5'd5, 5'd5);
    check("x5_before_edge", rs1data, 32'h0);
    tick();
    wen = 1'b0;
    read2(5'd5, 5'd5);
    check("x5_rs1", rs1data, 32'hDEADBEEF);
    check("x5_rs2", rs2data, 32'hDEADBEEF);
    read2(5'd4, 5'd6);
    check("x4_untouched", rs1data, 32'h0);
    check("x6_untouched", rs2data, 32'h0);

    // x0 protection.
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    wen = 1'b0;
    read2(5'd0, 5'd0);
    check("x0_rs1", rs1data, 32'h0);
    check("x0_rs2", rs2data, 32'h0);

    // No bypass on x10.
    wen = 1'b1; waddr = 5'd10; wdata = 32'h12345678;
    read2(5'd10, 5'd10);
    check("x10_old_rs1", rs1data, 32'h0);
    check("x10_old_rs2", rs2data, 32'h0);
    tick();
    wen = 1'b0;
    read2(5'd10, 5'd5);
    check("x10_new", rs1data, 32'h12345678);
    check("x5_kept", rs2data, 32'hDEADBEEF);

    // Write gating on x31, then enabled.
    wen = 1'b0; waddr = 5'd31; wdata = 32'h1;
    tick();
    read2(5'd31, 5'd31);
    check("x31_gated", rs1data, 32'h0);
    wen = 1'b1;
    tick();
    wen = 1'b0;
    read2(5'd31, 5'd31);
    check("x31_written_rs1", rs1data, 32'h1);
    check("x31_written_rs2", rs2data, 32'h1);

    // Distinct values into x1..x30.
    exp_val[0]  = 32'h0;
    exp_val[31] = 32'h1;
    for (int i = 1; i <= 30; i++) begin
      exp_val[i] = 32'hC0DE0000 | (32'(i) << 8) | 32'(i * 3);
      wen = 1'b1; waddr = 5'(i); wdata = exp_val[i];
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read2(5'(i), 5'(31 - i));
      check($sformatf("full_rs1_x%0d", i), rs1data, exp_val[i]);
      check($sformatf("full_rs2_x%0d", 31 - i), rs2data, exp_val[31 - i]);
    end

    // Reset asserted between edges has no effect until the next edge.
    #2;
    rst = 1'b0;
    read2(5'd5, 5'd7);
    check("rst_mid_x5", rs1data, exp_val[5]);
    check("rst_mid_x7", rs2data, exp_val[7]);

    // Reset priority over a simultaneous write to x7.
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    tick();
    wen = 1'b0;
    read2(5'd7, 5'd5);
    check("rst_prio_x7", rs1data, 32'h0);
    check("rst_prio_x5", rs2data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read2(5'(i), 5'(i));
      check($sformatf("rst_clr_x%0d", i), rs1data, 32'h0);
    end

    // Release reset between edges, then confirm writes work again.
    #2;
    rst = 1'b1;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h0BADF00D;
    tick();
    wen = 1'b0;
    read2(5'd9, 5'd8);
    check("after_rst_x9", rs1data, 32'h0BADF00D);
    check("after_rst_x8", rs2data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
